// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bus bundle between fetch/memory stages, the port arbiter and the unified memory
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              stall_f;
    logic              stall_m;
    logic              timeout_err;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
               stall_f, stall_m, timeout_err
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
               stall_f, stall_m, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fixed-priority (data over fetch) arbiter for one shared memory port
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        D_WAIT  = 2'd1,
        IF_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'hF;
    localparam logic [3:0] TO_LIM  = 4'(TIMEOUT);
`ifdef ARB_TIMEOUT_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    state_t            r_state;
    state_t            w_next;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [3:0]        r_cnt;
    logic              r_timeout_err;
    logic              w_grant_d;
    logic              w_grant_if;
    logic              w_if_valid;
    logic              w_d_valid;
    logic              w_to_hit;
    logic              w_wdog_fire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // An ack hands the port straight to the other requester so mem_req never dips.
    always_comb begin
        w_next      = r_state;
        w_grant_d   = 1'b0;
        w_grant_if  = 1'b0;
        w_if_valid  = 1'b0;
        w_d_valid   = 1'b0;
        w_wdog_fire = 1'b0;
        w_to_hit    = WDOG_EN && (r_cnt == TO_LIM);
        case (r_state)
            IDLE: begin
                if (bus.d_req) begin
                    w_next    = D_WAIT;
                    w_grant_d = 1'b1;
                end else if (bus.if_req) begin
                    w_next     = IF_WAIT;
                    w_grant_if = 1'b1;
                end
            end
            D_WAIT: begin
                if (bus.mem_ack) begin
                    w_d_valid = 1'b1;
                    if (bus.if_req) begin
                        w_next     = IF_WAIT;
                        w_grant_if = 1'b1;
                    end else begin
                        w_next = IDLE;
                    end
                end else if (w_to_hit) begin
                    w_d_valid   = 1'b1;
                    w_wdog_fire = 1'b1;
                    w_next      = IDLE;
                end
            end
            IF_WAIT: begin
                if (bus.mem_ack) begin
                    w_if_valid = 1'b1;
                    if (bus.d_req) begin
                        w_next    = D_WAIT;
                        w_grant_d = 1'b1;
                    end else begin
                        w_next = IDLE;
                    end
                end else if (w_to_hit) begin
                    w_if_valid  = 1'b1;
                    w_wdog_fire = 1'b1;
                    w_next      = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_mem_req     <= (w_next != IDLE);
            r_timeout_err <= r_timeout_err | w_wdog_fire;
            if (w_grant_d) begin
                r_mem_we    <= bus.d_we;
                r_mem_addr  <= bus.d_addr;
                r_mem_wdata <= bus.d_wdata;
            end else if (w_grant_if) begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= bus.if_addr;
                r_mem_wdata <= '0;
            end
            if (w_grant_d || w_grant_if)
                r_cnt <= '0;
            else if ((r_state != IDLE) && !bus.mem_ack && (r_cnt != CNT_MAX))
                r_cnt <= r_cnt + 4'd1;
        end
    end

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.if_valid    = w_if_valid;
    assign bus.d_valid     = w_d_valid;
    assign bus.if_rdata    = w_wdog_fire ? DATA_W'(32'hDEADBEEF) : bus.mem_rdata;
    assign bus.d_rdata     = w_wdog_fire ? DATA_W'(32'hDEADBEEF) : bus.mem_rdata;
    assign bus.stall_f     = bus.if_req & ~w_if_valid;
    assign bus.stall_m     = bus.d_req & ~w_d_valid;
    assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - vector table, directed corner cases and randomized transaction model for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_iv;
        logic        e_dv;
        logic        e_sf;
        logic        e_sm;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic run_random(input int ncyc);
        logic        f_out, d_out, d_we_r, ack, m_busy, m_new;
        logic        p_ireq, p_dreq, p_cont, exp_iv, exp_dv;
        logic [31:0] f_a, d_a, d_wd, rd;
        int          f_gap, d_gap, m_cnt, m_lat, kind, p_served;
        f_out = 0; d_out = 0; d_we_r = 0; f_a = 0; d_a = 0; d_wd = 0;
        f_gap = 0; d_gap = 1; m_cnt = 0; m_lat = 0; kind = 0;
        p_ireq = 0; p_dreq = 0; p_cont = 0; p_served = 0;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if (p_cont) begin
                m_busy = 1'b1;
            end else if (p_served == 1) begin
                m_busy = p_ireq; kind = 2;
            end else if (p_served == 2) begin
                m_busy = p_dreq; kind = 1;
            end else begin
                m_busy = p_dreq | p_ireq; kind = p_dreq ? 1 : 2;
            end
            m_new = m_busy && !p_cont;
            if (m_new) begin
                m_cnt = 0;
                m_lat = $urandom_range(0, 3);
            end
            ack = m_busy && (m_cnt == m_lat);
            rd  = $urandom;
            bus.if_req    = f_out;
            bus.if_addr   = f_a;
            bus.d_req     = d_out;
            bus.d_we      = d_we_r;
            bus.d_addr    = d_a;
            bus.d_wdata   = d_wd;
            bus.mem_ack   = ack;
            bus.mem_rdata = rd;
            settle();
            exp_dv = ack && (kind == 1);
            exp_iv = ack && (kind == 2);
            chk("rnd_mem_req", bus.mem_req, m_busy);
            if (m_new) begin
                chk("rnd_grant_addr", bus.mem_addr, (kind == 1) ? d_a : f_a);
                chk("rnd_grant_we", bus.mem_we, (kind == 1) ? d_we_r : 1'b0);
                chk("rnd_grant_wdata", bus.mem_wdata, (kind == 1) ? d_wd : 32'h0);
            end
            chk("rnd_d_valid", bus.d_valid, exp_dv);
            chk("rnd_if_valid", bus.if_valid, exp_iv);
            chk("rnd_stall_f", bus.stall_f, f_out && !exp_iv);
            chk("rnd_stall_m", bus.stall_m, d_out && !exp_dv);
            if (exp_dv && !d_we_r) chk("rnd_d_rdata", bus.d_rdata, rd);
            if (exp_iv) chk("rnd_if_rdata", bus.if_rdata, rd);
            p_ireq   = f_out;
            p_dreq   = d_out;
            p_served = ack ? kind : 0;
            p_cont   = m_busy && !ack;
            m_cnt++;
            if (exp_dv) begin
                d_out = 0; d_gap = $urandom_range(0, 2);
            end else if (!d_out) begin
                if (d_gap == 0) begin
                    d_out  = 1;
                    d_we_r = $urandom_range(0, 1);
                    d_a    = 32'h2000 | ($urandom_range(0, 63) << 2);
                    d_wd   = $urandom;
                end else d_gap--;
            end
            if (exp_iv) begin
                f_out = 0; f_gap = $urandom_range(0, 2);
            end else if (!f_out) begin
                if (f_gap == 0) begin
                    f_out = 1;
                    f_a   = 32'h1000 | ($urandom_range(0, 63) << 2);
                end else f_gap--;
            end
        end
        tick();
        idle_inputs();
        for (int c = 0; c < 8; c++) begin
            bus.mem_ack = bus.mem_req;
            tick();
        end
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int          hi, sm, dv, wc;
        logic        seen;
        vt[0]  = '{H, 32'h100, L, L, 32'h0,  32'h0,        L, 32'h0,        L, L, 32'h0,   32'h0,        L, L, H, L};
        vt[1]  = '{H, 32'h100, L, L, 32'h0,  32'h0,        H, 32'hE3A00005, H, L, 32'h100, 32'h0,        H, L, L, L};
        vt[2]  = '{L, 32'h0,   L, L, 32'h0,  32'h0,        L, 32'h0,        L, L, 32'h100, 32'h0,        L, L, L, L};
        vt[3]  = '{H, 32'h104, H, H, 32'h40, 32'h12345678, L, 32'h0,        L, L, 32'h100, 32'h0,        L, L, H, H};
        vt[4]  = '{H, 32'h104, H, H, 32'h40, 32'h12345678, H, 32'h0BADF00D, H, H, 32'h40,  32'h12345678, L, H, H, L};
        vt[5]  = '{H, 32'h104, L, L, 32'h0,  32'h0,        L, 32'h0,        H, L, 32'h104, 32'h0,        L, L, H, L};
        vt[6]  = '{H, 32'h104, L, L, 32'h0,  32'h0,        H, 32'hE2811001, H, L, 32'h104, 32'h0,        H, L, L, L};
        vt[7]  = '{L, 32'h0,   L, L, 32'h0,  32'h0,        L, 32'h0,        L, L, 32'h104, 32'h0,        L, L, L, L};
        vt[8]  = '{L, 32'h0,   L, L, 32'h0,  32'h0,        H, 32'hFFFFFFFF, L, L, 32'h104, 32'h0,        L, L, L, L};
        vt[9]  = '{L, 32'h0,   L, L, 32'h0,  32'h0,        L, 32'h0,        L, L, 32'h104, 32'h0,        L, L, L, L};
        vt[10] = '{L, 32'h0,   H, L, 32'h44, 32'h55,       L, 32'h0,        L, L, 32'h104, 32'h0,        L, L, L, H};
        vt[11] = '{L, 32'h0,   H, L, 32'h44, 32'h55,       H, 32'h77,       H, L, 32'h44,  32'h55,       L, H, L, L};
        vt[12] = '{L, 32'h0,   L, L, 32'h0,  32'h0,        L, 32'h0,        L, L, 32'h44,  32'h55,       L, L, L, L};

        reset = 1'b0;
        idle_inputs();
        bus.if_req  = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        tick();
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_if_valid", bus.if_valid, 1'b0);
        chk("rst_d_valid", bus.d_valid, 1'b0);
        chk("rst_stall_f", bus.stall_f, 1'b1);
        chk("rst_stall_m", bus.stall_m, 1'b0);
        chk("rst_timeout_err", bus.timeout_err, 1'b0);
        idle_inputs();
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            tick();
            bus.if_req    = vt[i].ireq;
            bus.if_addr   = vt[i].iaddr;
            bus.d_req     = vt[i].dreq;
            bus.d_we      = vt[i].dwe;
            bus.d_addr    = vt[i].daddr;
            bus.d_wdata   = vt[i].dwdata;
            bus.mem_ack   = vt[i].ack;
            bus.mem_rdata = vt[i].rdata;
            settle();
            chk($sformatf("vec%0d_mem_req", i), bus.mem_req, vt[i].e_mreq);
            chk($sformatf("vec%0d_mem_we", i), bus.mem_we, vt[i].e_mwe);
            chk($sformatf("vec%0d_mem_addr", i), bus.mem_addr, vt[i].e_maddr);
            chk($sformatf("vec%0d_mem_wdata", i), bus.mem_wdata, vt[i].e_mwdata);
            chk($sformatf("vec%0d_if_valid", i), bus.if_valid, vt[i].e_iv);
            chk($sformatf("vec%0d_d_valid", i), bus.d_valid, vt[i].e_dv);
            chk($sformatf("vec%0d_stall_f", i), bus.stall_f, vt[i].e_sf);
            chk($sformatf("vec%0d_stall_m", i), bus.stall_m, vt[i].e_sm);
            if (vt[i].e_iv) chk($sformatf("vec%0d_if_rdata", i), bus.if_rdata, vt[i].rdata);
            if (vt[i].e_dv && !vt[i].dwe) chk($sformatf("vec%0d_d_rdata", i), bus.d_rdata, vt[i].rdata);
        end

        // Load with the memory answering after 5 idle wait cycles.
        tick();
        idle_inputs();
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h80;
        hi = 0; sm = 0; dv = 0;
        for (int c = 0; c < 20; c++) begin
            bus.mem_ack   = bus.mem_req && (hi == 5);
            bus.mem_rdata = 32'hCAFE0080;
            if (bus.mem_req) hi++;
            settle();
            if (bus.stall_m) sm++;
            if (bus.d_valid) begin
                dv++;
                chk("slow_d_rdata", bus.d_rdata, 32'hCAFE0080);
            end
            tick();
            if (dv > 0) bus.d_req = 1'b0;
        end
        chk("slow_stall_cycles", sm, 6);
        chk("slow_valid_count", dv, 1);

        // Reset asserted in the middle of a data access.
        idle_inputs();
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h84;
        tick();
        settle();
        chk("midrst_granted", bus.mem_req, 1'b1);
        reset = 1'b0;
        #1;
        chk("midrst_mem_req_async", bus.mem_req, 1'b0);
        chk("midrst_d_valid", bus.d_valid, 1'b0);
        chk("midrst_stall_m", bus.stall_m, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        settle();
        chk("midrst_idle_after_release", bus.mem_req, 1'b0);
        tick();
        settle();
        chk("midrst_regrant_req", bus.mem_req, 1'b1);
        chk("midrst_regrant_addr", bus.mem_addr, 32'h84);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h00C0FFEE;
        #1;
        chk("midrst_d_valid_ack", bus.d_valid, 1'b1);
        tick();
        idle_inputs();

        run_random(3000);

        // Memory that never answers.
        idle_inputs();
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h88;
        wc = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            settle();
            if (bus.d_valid) begin
                seen = 1'b1;
                chk("wdog_d_rdata", bus.d_rdata, 32'hDEADBEEF);
            end else if (bus.mem_req) begin
                wc++;
            end
            tick();
        end
`ifdef ARB_TIMEOUT_EN
        chk("wdog_fired", seen, 1'b1);
        chk("wdog_wait_cycles", wc, 15);
        bus.d_req = 1'b0;
        settle();
        chk("wdog_mem_req_dropped", bus.mem_req, 1'b0);
        chk("wdog_err_set", bus.timeout_err, 1'b1);
        tick();
        tick();
        tick();
        chk("wdog_err_sticky", bus.timeout_err, 1'b1);
`else
        chk("nowdog_no_valid", seen, 1'b0);
        chk("nowdog_err_zero", bus.timeout_err, 1'b0);
        chk("nowdog_still_waiting", bus.mem_req, 1'b1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h12121212;
        #1;
        chk("nowdog_late_ack_valid", bus.d_valid, 1'b1);
        chk("nowdog_late_ack_rdata", bus.d_rdata, 32'h12121212);
        tick();
        idle_inputs();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
